// File: rtl/phrase_sequencer_pkg.sv
// phrase_pkg: shared definitions for the phrase sequencer.
//   word_id_t / word_e : 5-bit word identifiers (digits, operators, ...)
//   WORD_MAX           : highest identifier that owns a clip in flash
//   state_t            : sequencer FSM states
//   clip_t, clip_addr  : flash start/end byte address of a word's clip
package phrase_pkg;

    typedef logic [4:0] word_id_t;

    typedef enum word_id_t {
        WORD_ZERO     = 5'd0,
        WORD_ONE      = 5'd1,
        WORD_TWO      = 5'd2,
        WORD_THREE    = 5'd3,
        WORD_FOUR     = 5'd4,
        WORD_FIVE     = 5'd5,
        WORD_SIX      = 5'd6,
        WORD_SEVEN    = 5'd7,
        WORD_EIGHT    = 5'd8,
        WORD_NINE     = 5'd9,
        WORD_PLUS     = 5'd10,
        WORD_MINUS    = 5'd11,
        WORD_TIMES    = 5'd12,
        WORD_DIVIDE   = 5'd13,
        WORD_EQUALS   = 5'd14,
        WORD_POINT    = 5'd15,
        WORD_NEGATIVE = 5'd16,
        WORD_ERROR    = 5'd17
    } word_e;

    localparam word_id_t WORD_MAX = WORD_ERROR;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        START,
        WAIT,
        GAP,
        DONE
    } state_t;

    typedef struct packed {
        logic [23:0] start_addr;
        logic [23:0] end_addr;
    } clip_t;

    // Each clip owns one 64 KiB flash page selected by its word ID.
    function automatic clip_t clip_addr(input word_id_t id);
        clip_t c;
        c.start_addr = {3'b000, id, 16'h0000};
        c.end_addr   = {3'b000, id, 16'hFFFF};
        return c;
    endfunction

endpackage

// File: rtl/phrase_sequencer_token_fifo.sv
// token_fifo: synchronous FIFO of word IDs.
//   clk, reset (sync, active-low)
//   push/push_data : write a token (ignored when full)
//   pop            : drop the head token (ignored when empty)
//   clear          : empty the FIFO, wins over push/pop
//   head           : token at the read pointer
//   count          : tokens held; full/empty flags
module token_fifo
    import phrase_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  word_id_t                     push_data,
    input  logic                         pop,
    input  logic                         clear,
    output word_id_t                     head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    word_id_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/phrase_sequencer.sv
// phrase_sequencer: queues a phrase of word IDs and plays it clip by clip
// through the audio controller.
//   clk, reset (sync, active-low)
//   tok_id/tok_valid/tok_ready : token enqueue handshake (IDLE only)
//   clear                      : flush the queue (IDLE only)
//   play                       : start speaking the queued phrase
//   start_address/end_address  : clip byte range for the audio controller
//   start / finish             : clip start pulse / clip complete
//   busy, done                 : phrase in progress / phrase complete pulse
//   count                      : tokens currently queued
// Build option: define SEQ_GAP_EN to insert GAP_CYCLES of silence after
// every clip (including the last, before done).
module phrase_sequencer
    import phrase_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [4:0]                   tok_id,
    input  logic                         tok_valid,
    output logic                         tok_ready,
    input  logic                         clear,
    input  logic                         play,
    output logic [23:0]                  start_address,
    output logic [23:0]                  end_address,
    output logic                         start,
    input  logic                         finish,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    state_t    state;
    word_id_t  head;
    logic      full;
    logic      empty;
    logic      idle;
    logic      fifo_push;
    logic      fifo_pop;
    logic      fifo_clear;
    clip_t     clip;

    assign idle       = (state == IDLE);
    assign tok_ready  = idle && !full && !clear;
    assign fifo_push  = tok_valid && tok_ready;
    assign fifo_clear = idle && clear;
    assign fifo_pop   = (state == LOOKUP);
    assign clip       = clip_addr(head);

    token_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (tok_id),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

`ifdef SEQ_GAP_EN
    // A zero-length gap still spends one cycle in GAP.
    localparam int unsigned GW = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);

    logic [GW-1:0] gap_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            start         <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            start_address <= '0;
            end_address   <= '0;
`ifdef SEQ_GAP_EN
            gap_cnt       <= '0;
`endif
        end else begin
            start <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    // play with clear is dropped: the queue is being flushed.
                    if (play && !empty && !clear) begin
                        state <= LOOKUP;
                        busy  <= 1'b1;
                    end
                end
                LOOKUP: begin
                    // The head is popped this cycle regardless of validity;
                    // start rises together with the START state.
                    if (head <= WORD_MAX) begin
                        start_address <= clip.start_addr;
                        end_address   <= clip.end_addr;
                        start         <= 1'b1;
                        state         <= START;
                    end else if (count > CW'(1)) begin
                        state <= LOOKUP;
                    end else begin
                        state <= DONE;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (finish) begin
`ifdef SEQ_GAP_EN
                        gap_cnt <= '0;
                        state   <= GAP;
`else
                        state   <= empty ? DONE : LOOKUP;
`endif
                    end
                end
`ifdef SEQ_GAP_EN
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= empty ? DONE : LOOKUP;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phrase_sequencer.sv
// Scoreboard bench for phrase_sequencer. The driver keeps a model of the
// queue; on play it converts the phrase into expected start/done events
// (address pair plus timing relative to play or the previous finish).
// A monitor pops and checks events whenever start or done is seen, and a
// responder plays the audio controller by answering start with finish.
module tb_phrase_sequencer;

    localparam int unsigned DEPTH      = 8;
    localparam int unsigned GAP_CYCLES = 10;
`ifdef SEQ_GAP_EN
    localparam int GAPD = (GAP_CYCLES == 0) ? 1 : int'(GAP_CYCLES);
`else
    localparam int GAPD = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  tok_id = '0;
    logic        tok_valid = 1'b0;
    logic        tok_ready;
    logic        clear = 1'b0;
    logic        play = 1'b0;
    logic [23:0] start_address;
    logic [23:0] end_address;
    logic        start;
    logic        finish = 1'b0;
    logic        busy;
    logic        done;
    logic [3:0]  count;

    phrase_sequencer #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tok_id        (tok_id),
        .tok_valid     (tok_valid),
        .tok_ready     (tok_ready),
        .clear         (clear),
        .play          (play),
        .start_address (start_address),
        .end_address   (end_address),
        .start         (start),
        .finish        (finish),
        .busy          (busy),
        .done          (done),
        .count         (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        bit          first;    // timed from play rather than from a finish
        int          k;        // invalid tokens skipped just before this event
        logic [23:0] sa;
        logic [23:0] ea;
    } ev_t;

    ev_t        sb[$];
    logic [4:0] model_q[$];
    bit         model_idle = 1'b1;
    int         cyc = 0;
    int         play_cyc = 0;
    int         fin_cyc = 0;
    int         checks = 0;
    int         fails = 0;
    bit         auto_finish = 1'b1;
    int         fixed_delay = 0;
    bit         stray_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    ev_t mon_e;
    int  mon_exp;
    always @(negedge clk) begin
        if (reset && (start || done)) begin
            if (sb.size() == 0) begin
                check("spurious_event", {30'd0, start, done}, 32'd0);
            end else begin
                mon_e   = sb.pop_front();
                mon_exp = (mon_e.first ? play_cyc : fin_cyc + GAPD) + 1 + mon_e.k;
                check("event_kind", {31'd0, done}, {31'd0, mon_e.is_done});
                if (!mon_e.is_done) begin
                    check("start_address", start_address, mon_e.sa);
                    check("end_address", end_address, mon_e.ea);
                    check("start_cycle", cyc, mon_exp);
                end else begin
                    check("done_cycle", cyc, mon_exp);
                end
            end
        end
    end

    // Audio controller stand-in
    initial begin : responder
        int d;
        forever begin
            @(negedge clk);
            if (stray_req) begin
                stray_req = 1'b0;
                @(posedge clk); #1 finish = 1'b1;
                @(posedge clk); #1 finish = 1'b0;
            end else if (start && reset && auto_finish) begin
                d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 30));
                repeat (d) @(posedge clk);
                #1 finish = 1'b1;
                @(posedge clk); #1;
                fin_cyc = cyc;
                finish  = 1'b0;
            end
        end
    end

    // Turn the queued phrase into expected events.
    task automatic launch();
        int  k = 0;
        bit  first = 1'b1;
        ev_t e;
        foreach (model_q[i]) begin
            if (model_q[i] <= 5'd17) begin
                e.is_done = 1'b0;
                e.first   = first;
                e.k       = k;
                e.sa      = 24'(model_q[i]) << 16;
                e.ea      = e.sa + 24'h00FFFF;
                sb.push_back(e);
                first = 1'b0;
                k     = 0;
            end else begin
                k++;
            end
        end
        e.is_done = 1'b1;
        e.first   = first;
        e.k       = k;
        e.sa      = '0;
        e.ea      = '0;
        sb.push_back(e);
        play_cyc   = cyc;
        model_idle = 1'b0;
        model_q.delete();
    endtask

    // One clock of stimulus; entered and left #1 after a rising edge.
    task automatic drive(input bit v, input logic [4:0] id, input bit pl, input bit cl);
        bit exp_ready;
        int pre;
        tok_valid = v;
        tok_id    = id;
        play      = pl;
        clear     = cl;
        @(negedge clk);
        exp_ready = model_idle && (model_q.size() < DEPTH) && !cl;
        check("tok_ready", {31'd0, tok_ready}, {31'd0, exp_ready});
        if (model_idle) begin
            check("count", {28'd0, count}, model_q.size());
            check("busy_idle", {31'd0, busy}, 32'd0);
        end
        @(posedge clk); #1;
        tok_valid = 1'b0;
        play      = 1'b0;
        clear     = 1'b0;
        pre = model_q.size();
        if (model_idle && cl) model_q.delete();
        else if (v && exp_ready) model_q.push_back(id);
        if (pl && model_idle && pre > 0 && !cl) launch();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) drive(1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("busy_drop", {31'd0, busy}, 32'd0);
        model_idle = 1'b1;
        @(posedge clk); #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d cycles, expected fewer", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n;
        int len;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_start_address", start_address, 32'd0);
        check("rst_end_address", end_address, 32'd0);
        @(posedge clk); #1;

        // Reset while waiting for the first clip to finish.
        auto_finish = 1'b0;
        drive(1'b1, 5'd4, 1'b0, 1'b0);
        drive(1'b1, 5'd5, 1'b0, 1'b0);
        drive(1'b1, 5'd6, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        n = 0;
        while (start !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("first_start_seen", {31'd0, start}, 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        sb.delete();
        model_q.delete();
        model_idle = 1'b1;
        @(negedge clk);
        check("midwait_rst_start", {31'd0, start}, 32'd0);
        check("midwait_rst_busy", {31'd0, busy}, 32'd0);
        check("midwait_rst_count", {28'd0, count}, 32'd0);
        check("midwait_rst_start_address", start_address, 32'd0);
        check("midwait_rst_end_address", end_address, 32'd0);
        @(posedge clk); #1;
        auto_finish = 1'b1;

        // Fixed 20-cycle clips: 4, plus, 2.
        fixed_delay = 20;
        drive(1'b1, 5'd4, 1'b0, 1'b0);
        drive(1'b1, 5'd10, 1'b0, 1'b0);
        drive(1'b1, 5'd2, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        wait_idle(500);
        fixed_delay = 0;

        // Fill past capacity, play with a rejected push, push while busy.
        for (int i = 0; i < 9; i++) drive(1'b1, 5'($urandom_range(0, 31)), 1'b0, 1'b0);
        drive(1'b1, 5'd3, 1'b1, 1'b0);
        drive(1'b1, 5'd7, 1'b0, 1'b0);
        wait_idle(3000);

        // Invalid ID in the middle is skipped.
        drive(1'b1, 5'd5, 1'b0, 1'b0);
        drive(1'b1, 5'd31, 1'b0, 1'b0);
        drive(1'b1, 5'd14, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        wait_idle(500);

        // Play on an empty queue with a simultaneous push is ignored.
        drive(1'b1, 5'd9, 1'b1, 1'b0);
        idle_cycles(2);
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        wait_idle(500);

        // Play with nothing queued.
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        idle_cycles(3);

        // Clear beats a push; later play and a stray finish do nothing.
        drive(1'b1, 5'd3, 1'b0, 1'b0);
        drive(1'b1, 5'd8, 1'b0, 1'b0);
        drive(1'b1, 5'd12, 1'b0, 1'b1);
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        stray_req = 1'b1;
        idle_cycles(5);

        // Random phrases, including invalid IDs at either end.
        for (int p = 0; p < 8; p++) begin
            len = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < len; i++) begin
                drive(1'b1, 5'($urandom_range(0, 31)), 1'b0, 1'b0);
                if ($urandom_range(0, 3) == 0) idle_cycles(1);
            end
            drive(1'b0, 5'd0, 1'b1, 1'b0);
            wait_idle(3000);
        end

        idle_cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
